// File: rtl/arbitrated_fifo_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arbitrated_fifo_bank_pkg
//  Description : Shared helpers for the arbitrated FIFO bank: width
//                functions and the round-robin priority pick used both by
//                the read arbiter and by the push redirect search.
//  Revision    : 1.0 - initial release
// ============================================================================
package arbitrated_fifo_bank_pkg;

    // Upper bound on channel count handled by the priority helpers.
    localparam int c_MAX_CH    = 64;
    localparam int c_MAX_IDX_W = 6;

    // Ceiling log2, minimum 1 so that index vectors never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    // Channel-index width for a bank of n channels.
    function automatic int tag_width(input int n);
        return clog2(n);
    endfunction

    // Occupancy counter width for a FIFO of the given depth (one extra wrap bit).
    function automatic int count_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Round-robin pick: lowest set bit at or above start, else lowest set bit overall.
    function automatic logic [c_MAX_CH-1:0] rr_pick(input logic [c_MAX_CH-1:0]    req,
                                                    input logic [c_MAX_IDX_W-1:0] start);
        logic [c_MAX_CH-1:0] masked;
        logic [c_MAX_CH-1:0] hi;
        logic [c_MAX_CH-1:0] lo;
        masked = req & ({c_MAX_CH{1'b1}} << start);
        hi     = masked & (~masked + 1'b1);
        lo     = req & (~req + 1'b1);
        return (|masked) ? hi : lo;
    endfunction

    // One-hot to binary index; zero input maps to index 0.
    function automatic logic [c_MAX_IDX_W-1:0] oh2idx(input logic [c_MAX_CH-1:0] oh);
        logic [c_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < c_MAX_CH; i++) begin
            if (oh[i]) idx = idx | c_MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/circular_pointer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : circular_pointer_fifo
//  Description : Single-clock FIFO with wrap-bit read/write pointers,
//                registered storage and combinational head read.
//  Revision    : 1.0 - initial release
// ============================================================================
module circular_pointer_fifo
    import arbitrated_fifo_bank_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [CW-1:0]    r_wptr;
    logic [CW-1:0]    r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_wr;
    logic w_do_rd;

    // Full when the wrap bits differ but the address bits match.
    assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty   = (r_wptr == r_rptr);
    assign count   = r_wptr - r_rptr;
    assign rd_data = r_mem[r_rptr[AW-1:0]];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_do_wr = wr_en && !full;
    assign w_do_rd = rd_en && !empty;

    // Pointer update; reset discards all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + 1'b1;
            if (w_do_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; no reset needed since empty masks stale entries.
    always_ff @(posedge clk) begin
        if (w_do_wr && !rst) r_mem[r_wptr[AW-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : round_robin_arbiter
//  Description : Round-robin arbiter with a registered priority pointer.
//                The pointer moves past the granted index only on advance,
//                so the grant is stable under backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter
    import arbitrated_fifo_bank_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IW    = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] requests,
    input  logic             advance,
    output logic [WIDTH-1:0] gnt,
    output logic [IW-1:0]    gnt_idx
);

    logic [IW-1:0]       r_ptr;
    logic [c_MAX_CH-1:0] w_req_ext;
    logic [c_MAX_CH-1:0] w_gnt_ext;

    assign w_req_ext = c_MAX_CH'(requests);
    assign gnt       = en ? WIDTH'(rr_pick(w_req_ext, c_MAX_IDX_W'(r_ptr))) : '0;
    assign w_gnt_ext = c_MAX_CH'(gnt);
    assign gnt_idx   = IW'(oh2idx(w_gnt_ext));

    // Priority pointer moves to the slot after the winner when the grant is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && (|gnt)) begin
            r_ptr <= (gnt_idx == IW'(WIDTH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arbitrated_fifo_bank.sv
`default_nettype none
// ============================================================================
//  Module      : arbitrated_fifo_bank
//  Description : Bank of tagged FIFOs with one steered write port (optional
//                redirect of pushes aimed at a full FIFO) and one
//                round-robin arbitrated valid/ready read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module arbitrated_fifo_bank
    import arbitrated_fifo_bank_pkg::*;
#(
    parameter  int NUM_FIFOS = 4,
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 4,
    parameter  int REDIRECT  = 1,
    localparam int TAGWIDTH  = tag_width(NUM_FIFOS),
    localparam int CW        = count_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [TAGWIDTH-1:0]     push_sel,
    input  logic [WIDTH-1:0]        data_in,
    output logic                    push_acc,
    output logic [TAGWIDTH-1:0]     push_tag,
    input  logic [NUM_FIFOS-1:0]    reqs,
    input  logic                    out_rdy,
    output logic                    out_vld,
    output logic [WIDTH-1:0]        out_data,
    output logic [TAGWIDTH-1:0]     out_tag,
    output logic [NUM_FIFOS-1:0]    gnt,
    output logic [NUM_FIFOS-1:0]    full,
    output logic [NUM_FIFOS-1:0]    empty,
    output logic [NUM_FIFOS*CW-1:0] occupancy
);

    logic [NUM_FIFOS-1:0] w_full;
    logic [NUM_FIFOS-1:0] w_empty;
    logic [NUM_FIFOS-1:0] w_not_full;
    logic [NUM_FIFOS-1:0] w_wr_en;
    logic [NUM_FIFOS-1:0] w_rd_en;
    logic [NUM_FIFOS-1:0] w_elig;
    logic [NUM_FIFOS-1:0] w_gnt;
    logic [TAGWIDTH-1:0]  w_gnt_idx;
    logic [WIDTH-1:0]     w_head  [NUM_FIFOS];
    logic [CW-1:0]        w_count [NUM_FIFOS];

    logic                 w_sel_full;
    logic [TAGWIDTH-1:0]  w_redir_start;
    logic [NUM_FIFOS-1:0] w_redir_oh;
    logic [TAGWIDTH-1:0]  w_redir_tag;
    logic [c_MAX_CH-1:0]  w_not_full_ext;
    logic [c_MAX_CH-1:0]  w_redir_oh_ext;

    // ---------------------------------------------------------------- push path
    // Redirect search starts just after the requested channel; it has its own
    // start point and never touches the read arbiter's pointer.
    assign w_not_full     = ~w_full;
    assign w_sel_full     = w_full[push_sel];
    assign w_redir_start  = (push_sel == TAGWIDTH'(NUM_FIFOS - 1)) ? '0 : push_sel + 1'b1;
    assign w_not_full_ext = c_MAX_CH'(w_not_full);
    assign w_redir_oh     = NUM_FIFOS'(rr_pick(w_not_full_ext, c_MAX_IDX_W'(w_redir_start)));
    assign w_redir_oh_ext = c_MAX_CH'(w_redir_oh);
    assign w_redir_tag    = TAGWIDTH'(oh2idx(w_redir_oh_ext));

    // Accept decision on current full flags; a same-cycle pop never frees space.
    always_comb begin
        push_acc = 1'b0;
        push_tag = '0;
        if (push) begin
            if (!w_sel_full) begin
                push_acc = 1'b1;
                push_tag = push_sel;
            end else if ((REDIRECT != 0) && (|w_redir_oh)) begin
                push_acc = 1'b1;
                push_tag = w_redir_tag;
            end
        end
    end

    // ---------------------------------------------------------------- read path
    assign w_elig = reqs & ~w_empty;

    round_robin_arbiter #(
        .WIDTH    (NUM_FIFOS)
    ) u_read_arb (
        .clk      (clk),
        .rst      (rst),
        .en       (1'b1),
        .requests (w_elig),
        .advance  (out_vld && out_rdy),
        .gnt      (w_gnt),
        .gnt_idx  (w_gnt_idx)
    );

    assign out_vld  = |w_elig;
    assign gnt      = w_gnt;
    assign out_tag  = w_gnt_idx;
    assign out_data = out_vld ? w_head[w_gnt_idx] : '0;
    assign full     = w_full;
    assign empty    = w_empty;

    // ---------------------------------------------------------------- channels
    for (genvar k = 0; k < NUM_FIFOS; k++) begin : g_chan
        assign w_wr_en[k] = push_acc && (push_tag == TAGWIDTH'(k)) && !rst;
        assign w_rd_en[k] = w_gnt[k] && out_rdy;
        assign occupancy[k*CW +: CW] = w_count[k];

        circular_pointer_fifo #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (w_wr_en[k]),
            .wr_data (data_in),
            .rd_en   (w_rd_en[k]),
            .rd_data (w_head[k]),
            .full    (w_full[k]),
            .empty   (w_empty[k]),
            .count   (w_count[k])
        );
    end

    // ---------------------------------------------------------------- properties
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(w_gnt));
    a_gnt_subset  : assert property (@(posedge clk) disable iff (rst) ((w_gnt & ~w_elig) == '0));
    a_no_full_wr  : assert property (@(posedge clk) disable iff (rst) ((w_wr_en & w_full) == '0));

endmodule
`default_nettype wire
